// File: rtl/cvxif_initiator_pkg.sv
// ======================================================================
// cvxif_initiator_pkg: shared FSM state and commit types | Rev 1.0
// ======================================================================
`default_nettype none

package cvxif_initiator_pkg;

  // Widest ID the initiator supports (Depth up to 16)
  localparam int MAX_ID_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_COMMIT = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic                kill;
  } commit_t;

endpackage

`default_nettype wire

// File: rtl/cvxif_id_scoreboard.sv
// ======================================================================
// cvxif_id_scoreboard: outstanding-ID set/clear/lookup | Rev 1.0
// ======================================================================
`default_nettype none

module cvxif_id_scoreboard #(
  parameter int Depth   = 4,
  parameter int IdWidth = $clog2(Depth)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en,
  input  logic [IdWidth-1:0] set_id,
  input  logic               clr_en,
  input  logic [IdWidth-1:0] clr_id,
  input  logic [IdWidth-1:0] issue_id,
`ifdef CVXIF_ID_CHECK_EN
  input  logic [IdWidth-1:0] result_id,
  output logic               result_known,
`endif
  output logic               issue_busy
);

  logic [Depth-1:0] outstanding;

  // Clear is applied before set so a same-ID collision leaves the new issue marked
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      if (clr_en) outstanding[clr_id] <= 1'b0;
      if (set_en) outstanding[set_id] <= 1'b1;
    end
  end

  assign issue_busy = outstanding[issue_id];

`ifdef CVXIF_ID_CHECK_EN
  assign result_known = outstanding[result_id];
`endif

endmodule

`default_nettype wire

// File: rtl/cvxif_issue_initiator.sv
// ======================================================================
// cvxif_issue_initiator: CV-X-IF offload issue/commit/result initiator | Rev 1.0
// Optional macro CVXIF_ID_CHECK_EN: drop and flag results with unknown IDs
// ======================================================================
`default_nettype none

module cvxif_issue_initiator
  import cvxif_initiator_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NrRgprPorts = 2,
  parameter int Depth       = 4,
  parameter int IdWidth     = $clog2(Depth)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        off_valid_i,
  output logic                        off_ready_o,
  input  logic [31:0]                 off_instr_i,
  input  logic [NrRgprPorts*XLEN-1:0] off_rs_i,
  output logic                        x_issue_valid_o,
  input  logic                        x_issue_ready_i,
  output logic [31:0]                 x_issue_instr_o,
  output logic [IdWidth-1:0]          x_issue_id_o,
  input  logic                        x_issue_accept_i,
  input  logic                        x_issue_writeback_i,
  output logic                        x_register_valid_o,
  output logic [NrRgprPorts*XLEN-1:0] x_register_rs_o,
  output logic                        x_commit_valid_o,
  output logic [IdWidth-1:0]          x_commit_id_o,
  output logic                        x_commit_kill_o,
  input  logic                        x_result_valid_i,
  output logic                        x_result_ready_o,
  input  logic [IdWidth-1:0]          x_result_id_i,
  input  logic [XLEN-1:0]             x_result_data_i,
  input  logic [4:0]                  x_result_rd_i,
  input  logic                        x_result_we_i,
  output logic                        wb_valid_o,
  input  logic                        wb_ready_i,
  output logic [4:0]                  wb_rd_o,
  output logic [XLEN-1:0]             wb_data_o,
  output logic                        wb_we_o,
  output logic                        ill_o,
  output logic                        err_o
);

  issue_state_e                state_q, state_d;
  logic [IdWidth-1:0]          next_id_q;
  logic [IdWidth-1:0]          issue_id_q;
  logic [31:0]                 instr_q;
  logic [NrRgprPorts*XLEN-1:0] rs_q;
  commit_t                     commit_q;

  logic next_busy;
  logic off_hs;
  logic issue_hs;
  logic issue_set;
  logic res_hs;
  logic res_fwd;
  logic res_err;

  // ---------------- issue FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Handshake outputs are masked while reset is asserted
  always_comb begin
    state_d            = state_q;
    off_ready_o        = 1'b0;
    x_issue_valid_o    = 1'b0;
    x_register_valid_o = 1'b0;
    x_commit_valid_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        off_ready_o = ~rst_i & ~next_busy;
        if (off_valid_i && off_ready_o) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        x_issue_valid_o    = ~rst_i;
        x_register_valid_o = ~rst_i;
        if (x_issue_ready_i) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        x_commit_valid_o = ~rst_i;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign off_hs    = off_valid_i & off_ready_o;
  assign issue_hs  = x_issue_valid_o & x_issue_ready_i;
  assign issue_set = issue_hs & x_issue_accept_i & x_issue_writeback_i;
  assign ill_o     = issue_hs & ~x_issue_accept_i;

  // ---------------- issue / commit payload ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      next_id_q  <= '0;
      issue_id_q <= '0;
      instr_q    <= '0;
      rs_q       <= '0;
      commit_q   <= '0;
    end else begin
      if (off_hs) begin
        instr_q    <= off_instr_i;
        rs_q       <= off_rs_i;
        issue_id_q <= next_id_q;
      end
      if (issue_hs) begin
        next_id_q     <= next_id_q + IdWidth'(1);
        commit_q.id   <= MAX_ID_W'(issue_id_q);
        commit_q.kill <= ~x_issue_accept_i;
      end
    end
  end

  assign x_issue_instr_o = instr_q;
  assign x_issue_id_o    = issue_id_q;
  assign x_register_rs_o = rs_q;
  assign x_commit_id_o   = IdWidth'(commit_q.id);
  assign x_commit_kill_o = commit_q.kill;

  // ---------------- outstanding scoreboard ----------------
`ifdef CVXIF_ID_CHECK_EN
  logic result_known;
`endif

  cvxif_id_scoreboard #(
    .Depth   (Depth),
    .IdWidth (IdWidth)
  ) u_scoreboard (
    .clk          (clk_i),
    .rst          (rst_i),
    .set_en       (issue_set),
    .set_id       (issue_id_q),
    .clr_en       (res_hs),
    .clr_id       (x_result_id_i),
    .issue_id     (next_id_q),
`ifdef CVXIF_ID_CHECK_EN
    .result_id    (x_result_id_i),
    .result_known (result_known),
`endif
    .issue_busy   (next_busy)
  );

  // ---------------- result / writeback path ----------------
  assign x_result_ready_o = ~rst_i & (~wb_valid_o | wb_ready_i);
  assign res_hs           = x_result_valid_i & x_result_ready_o;

`ifdef CVXIF_ID_CHECK_EN
  assign res_fwd = result_known;
  assign res_err = ~result_known;
`else
  assign res_fwd = 1'b1;
  assign res_err = 1'b0;
`endif

  assign err_o = res_hs & res_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_o <= 1'b0;
      wb_rd_o    <= '0;
      wb_data_o  <= '0;
      wb_we_o    <= 1'b0;
    end else if (res_hs && res_fwd) begin
      wb_valid_o <= 1'b1;
      wb_rd_o    <= x_result_rd_i;
      wb_data_o  <= x_result_data_i;
      wb_we_o    <= x_result_we_i;
    end else if (wb_ready_i) begin
      wb_valid_o <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cvxif_issue_initiator.sv
// ======================================================================
// tb_cvxif_issue_initiator: directed + random bench with transaction model | Rev 1.0
// ======================================================================
`default_nettype none

module tb_cvxif_issue_initiator;

  localparam int XLEN  = 32;
  localparam int NR    = 2;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;
`ifdef CVXIF_ID_CHECK_EN
  localparam bit IDCHK = 1'b1;
`else
  localparam bit IDCHK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               off_valid;
  logic               off_ready;
  logic [31:0]        off_instr;
  logic [NR*XLEN-1:0] off_rs;
  logic               issue_valid;
  logic               issue_ready;
  logic [31:0]        issue_instr;
  logic [IDW-1:0]     issue_id;
  logic               issue_accept;
  logic               issue_wb;
  logic               reg_valid;
  logic [NR*XLEN-1:0] reg_rs;
  logic               commit_valid;
  logic [IDW-1:0]     commit_id;
  logic               commit_kill;
  logic               res_valid;
  logic               res_ready;
  logic [IDW-1:0]     res_id;
  logic [XLEN-1:0]    res_data;
  logic [4:0]         res_rd;
  logic               res_we;
  logic               wb_valid;
  logic               wb_ready;
  logic [4:0]         wb_rd;
  logic [XLEN-1:0]    wb_data;
  logic               wb_we;
  logic               ill;
  logic               err;

  always #5 clk = ~clk;

  cvxif_issue_initiator #(
    .XLEN(XLEN), .NrRgprPorts(NR), .Depth(DEPTH), .IdWidth(IDW)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .off_valid_i         (off_valid),
    .off_ready_o         (off_ready),
    .off_instr_i         (off_instr),
    .off_rs_i            (off_rs),
    .x_issue_valid_o     (issue_valid),
    .x_issue_ready_i     (issue_ready),
    .x_issue_instr_o     (issue_instr),
    .x_issue_id_o        (issue_id),
    .x_issue_accept_i    (issue_accept),
    .x_issue_writeback_i (issue_wb),
    .x_register_valid_o  (reg_valid),
    .x_register_rs_o     (reg_rs),
    .x_commit_valid_o    (commit_valid),
    .x_commit_id_o       (commit_id),
    .x_commit_kill_o     (commit_kill),
    .x_result_valid_i    (res_valid),
    .x_result_ready_o    (res_ready),
    .x_result_id_i       (res_id),
    .x_result_data_i     (res_data),
    .x_result_rd_i       (res_rd),
    .x_result_we_i       (res_we),
    .wb_valid_o          (wb_valid),
    .wb_ready_i          (wb_ready),
    .wb_rd_o             (wb_rd),
    .wb_data_o           (wb_data),
    .wb_we_o             (wb_we),
    .ill_o               (ill),
    .err_o               (err)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Transaction-level model: which IDs await a result, and the next ID to hand out
  bit out_m[DEPTH];
  int nid_m;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [4:0]  rd;
    bit          we;
  } res_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < DEPTH; i++) out_m[i] = 1'b0;
    nid_m = 0;
  endtask

  task automatic set_defaults;
    off_valid = 0; off_instr = '0; off_rs = '0;
    issue_ready = 0; issue_accept = 0; issue_wb = 0;
    res_valid = 0; res_id = '0; res_data = '0; res_rd = '0; res_we = 0;
    wb_ready = 1;
  endtask

  // One full IDLE -> ISSUE -> COMMIT transaction; caller guarantees next ID is free
  task automatic offload(input logic [31:0] instr, input logic [63:0] rs,
                         input bit acc, input bit wbk, input int stall);
    int id;
    id = nid_m;
    off_valid = 1; off_instr = instr; off_rs = rs;
    @(negedge clk);
    check("off_ready", off_ready, 1);
    tick;
    off_valid = 0; off_instr = $urandom(); off_rs = {$urandom(), $urandom()};
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("issue_valid_hold", issue_valid, 1);
      check("issue_instr_hold", issue_instr, instr);
      check("register_rs_hold", reg_rs, rs);
      check("issue_id_hold", issue_id, id);
      tick;
    end
    issue_ready = 1; issue_accept = acc; issue_wb = wbk;
    @(negedge clk);
    check("issue_valid", issue_valid, 1);
    check("register_valid", reg_valid, 1);
    check("issue_id", issue_id, id);
    check("issue_instr", issue_instr, instr);
    check("register_rs", reg_rs, rs);
    check("ill_pulse", ill, !acc);
    check("off_ready_busy", off_ready, 0);
    tick;
    issue_ready = 0; issue_accept = 0; issue_wb = 0;
    if (acc && wbk) out_m[id] = 1'b1;
    nid_m = (nid_m + 1) % DEPTH;
    @(negedge clk);
    check("commit_valid", commit_valid, 1);
    check("commit_id", commit_id, id);
    check("commit_kill", commit_kill, !acc);
    check("issue_valid_after", issue_valid, 0);
    check("ill_after", ill, 0);
    tick;
    @(negedge clk);
    check("commit_one_cycle", commit_valid, 0);
    check("off_ready_idle", off_ready, !out_m[nid_m]);
    tick;
  endtask

  task automatic check_wb(input bit fwd, input res_t r);
    check("wb_valid", wb_valid, fwd);
    if (fwd) begin
      check("wb_data", wb_data, r.data);
      check("wb_rd", wb_rd, r.rd);
      check("wb_we", wb_we, r.we);
    end
  endtask

  // Back-to-back results with wb_ready held high; FSM assumed idle
  task automatic results(input res_t q[$]);
    bit   prev_fwd;
    bit   known;
    res_t prev;
    prev_fwd = 0;
    foreach (q[i]) begin
      known = out_m[q[i].id];
      res_valid = 1; res_id = IDW'(q[i].id); res_data = q[i].data;
      res_rd = q[i].rd; res_we = q[i].we;
      @(negedge clk);
      check("result_ready", res_ready, 1);
      check("err_pulse", err, IDCHK && !known);
      if (i > 0) check_wb(prev_fwd, prev);
      tick;
      out_m[q[i].id] = 1'b0;
      prev_fwd = !IDCHK || known;
      prev = q[i];
    end
    res_valid = 0;
    @(negedge clk);
    check_wb(prev_fwd, prev);
    check("err_idle", err, 0);
    check("off_ready_after_result", off_ready, !out_m[nid_m]);
    tick;
  endtask

  task automatic drain_all;
    res_t q[$];
    res_t e;
    for (int i = 0; i < DEPTH; i++) begin
      if (out_m[i]) begin
        e.id = i; e.data = $urandom(); e.rd = 5'($urandom()); e.we = 1'($urandom());
        q.insert($urandom_range(q.size(), 0), e);
      end
    end
    if (q.size() > 0) results(q);
  endtask

  initial begin
    res_t q[$];
    res_t e;
    int   y;

    // ---- reset state ----
    set_defaults();
    rst = 1; off_valid = 1; res_valid = 1; issue_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_off_ready", off_ready, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_register_valid", reg_valid, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_result_ready", res_ready, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_ill", ill, 0);
    check("rst_err", err, 0);
    check("rst_issue_instr", issue_instr, 0);
    check("rst_wb_data", wb_data, 0);
    tick;
    rst = 0; set_defaults(); model_reset();
    @(negedge clk);
    check("post_rst_off_ready", off_ready, 1);
    check("post_rst_result_ready", res_ready, 1);
    tick;

    // ---- basic offload + result ----
    offload(32'h0000_000B, {32'd7, 32'd5}, 1, 1, 0);
    q = {}; e.id = 0; e.data = 12; e.rd = 3; e.we = 1; q.push_back(e);
    results(q);

    // ---- reject ----
    offload(32'h1234_567B, {32'd1, 32'd2}, 0, 1, 0);

    // ---- issue stall for 5 cycles, no writeback ----
    offload(32'hCAFE_F00B, {32'hDEAD_BEEF, 32'h0BAD_F00D}, 1, 0, 5);

    // ---- writeback backpressure and unexpected ID ----
    offload(32'h0000_102B, {32'd9, 32'd8}, 1, 1, 0);
    wb_ready = 0;
    res_valid = 1; res_id = 2'd3; res_data = 32'h55AA_0001; res_rd = 5'd17; res_we = 1;
    @(negedge clk);
    check("bp_first_ready", res_ready, 1);
    tick;
    out_m[3] = 1'b0;
    y = 2;
    res_id = IDW'(y); res_data = 32'h7777_0002; res_rd = 5'd4; res_we = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_result_ready", res_ready, 0);
      check("bp_wb_valid", wb_valid, 1);
      check("bp_wb_data", wb_data, 32'h55AA_0001);
      check("bp_wb_rd", wb_rd, 17);
      tick;
    end
    wb_ready = 1;
    @(negedge clk);
    check("bp_release_ready", res_ready, 1);
    check("bp_unknown_err", err, IDCHK && !out_m[y]);
    tick;
    res_valid = 0;
    @(negedge clk);
    check("bp_unknown_wb_valid", wb_valid, !IDCHK);
    if (!IDCHK) check("bp_unknown_wb_data", wb_data, 32'h7777_0002);
    check("bp_err_clear", err, 0);
    out_m[y] = 1'b0;
    tick;
    tick;

    // ---- ID wrap onto an outstanding ID ----
    check("wrap_start_id", nid_m, 0);
    offload($urandom(), {$urandom(), $urandom()}, 1, 1, 0);
    for (int i = 1; i < DEPTH; i++) offload($urandom(), {$urandom(), $urandom()}, 1, 1, 0);
    q = {};
    e.id = 3; e.data = 32'h33; e.rd = 5'd13; e.we = 1; q.push_back(e);
    e.id = 1; e.data = 32'h11; e.rd = 5'd11; e.we = 1; q.push_back(e);
    e.id = 2; e.data = 32'h22; e.rd = 5'd12; e.we = 0; q.push_back(e);
    results(q);
    off_valid = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wrap_stall_off_ready", off_ready, 0);
      tick;
    end
    off_valid = 0;
    q = {}; e.id = 0; e.data = 32'hA0; e.rd = 5'd10; e.we = 1; q.push_back(e);
    results(q);

    // ---- reset while an offload sits in ISSUE ----
    off_valid = 1; off_instr = 32'hFFFF_000B; off_rs = {32'd3, 32'd4};
    tick;
    off_valid = 0;
    @(negedge clk);
    check("pre_rst_issue_valid", issue_valid, 1);
    rst = 1; issue_ready = 1; issue_accept = 1; issue_wb = 1;
    tick;
    rst = 0; issue_ready = 0; issue_accept = 0; issue_wb = 0;
    model_reset();
    @(negedge clk);
    check("midrst_issue_valid", issue_valid, 0);
    check("midrst_commit_valid", commit_valid, 0);
    check("midrst_issue_instr", issue_instr, 0);
    check("midrst_off_ready", off_ready, 1);
    tick;
    @(negedge clk);
    check("midrst_no_commit", commit_valid, 0);
    tick;

    // ---- randomized traffic ----
    for (int it = 0; it < 40; it++) begin
      if (out_m[nid_m]) begin
        @(negedge clk);
        check("rand_stall_off_ready", off_ready, 0);
        tick;
        drain_all();
      end else if ($urandom_range(3, 0) == 0) begin
        q = {};
        for (int i = 0; i < DEPTH; i++) begin
          if (out_m[i] || (IDCHK && $urandom_range(5, 0) == 0)) begin
            e.id = i; e.data = $urandom(); e.rd = 5'($urandom()); e.we = 1'($urandom());
            q.insert($urandom_range(q.size(), 0), e);
          end
        end
        if (q.size() > 0) results(q);
      end else begin
        offload($urandom(), {$urandom(), $urandom()},
                $urandom_range(3, 0) != 0, 1'($urandom()), $urandom_range(2, 0));
      end
    end
    drain_all();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Watchdog in case the bench itself stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/cvxif_issue_initiator.md
CVXIF_ISSUE_INITIATOR -- requirements
Module: cvxif_issue_initiator

Interface
REQ-001 Parameters: XLEN=32, operand width; NrRgprPorts=2, source operands per offload; Depth=4, max outstanding offloads (power of 2, 2..16); IdWidth=$clog2(Depth), ID field width.
REQ-002 Ports: clk_i in 1, clock; one clock domain; reset is synchronous and active-high.
REQ-003 Ports: rst_i in 1, synchronous active-high reset.
REQ-004 Ports: off_valid_i in 1 / off_ready_o out 1, core offload request handshake.
REQ-005 Ports: off_instr_i in 32, off_rs_i in NrRgprPorts*XLEN, instruction and operand values.
REQ-006 Ports: x_issue_valid_o out 1 / x_issue_ready_i in 1; x_issue_instr_o out 32; x_issue_id_o out IdWidth.
REQ-007 Ports: x_issue_accept_i in 1, x_issue_writeback_i in 1, coprocessor issue response.
REQ-008 Ports: x_register_valid_o out 1, x_register_rs_o out NrRgprPorts*XLEN; register_ready is issue_ready (no split).
REQ-009 Ports: x_commit_valid_o out 1, x_commit_id_o out IdWidth, x_commit_kill_o out 1.
REQ-010 Ports: x_result_valid_i in 1 / x_result_ready_o out 1; x_result_id_i in IdWidth, x_result_data_i in XLEN, x_result_rd_i in 5, x_result_we_i in 1.
REQ-011 Ports: wb_valid_o out 1 / wb_ready_i in 1; wb_rd_o out 5, wb_data_o out XLEN, wb_we_o out 1.
REQ-012 Ports: ill_o out 1, one-cycle pulse when the coprocessor rejects an instruction; err_o out 1, one-cycle pulse on an unexpected result ID.

Function
REQ-013 Issue FSM states: IDLE, ISSUE, COMMIT.
REQ-014 IDLE: off_ready_o=1 iff outstanding[next_id]=0; an off handshake registers instr/rs, assigns x_issue_id_o=next_id, and moves to ISSUE.
REQ-015 ISSUE: x_issue_valid_o=x_register_valid_o=1 from the cycle after the off handshake; payload stays stable until x_issue_ready_i=1.
REQ-016 ISSUE handshake: sample accept/writeback, then move to COMMIT; next_id increments mod Depth.
REQ-017 Accept with writeback=1 sets outstanding[id]; accept with writeback=0 sets nothing.
REQ-018 Reject (accept=0): ill_o pulses in the handshake cycle; outstanding is unchanged.
REQ-019 COMMIT: x_commit_valid_o=1 for exactly one cycle, x_commit_id_o=issued id, x_commit_kill_o=~accept; then return to IDLE.
REQ-020 Minimum offload-to-offload spacing is 3 cycles (IDLE, ISSUE, COMMIT).
REQ-021 Result path: x_result_ready_o = ~wb_valid_o | wb_ready_i.
REQ-022 Result handshake loads the wb_* register (wb_valid_o next cycle, 1-cycle latency) and clears outstanding[x_result_id_i].
REQ-023 wb_valid_o stays high with a stable payload until wb_ready_i=1; back-to-back results give full throughput when wb_ready_i=1.
REQ-024 Results may return out of order; next_id wrap onto a still-outstanding ID stalls off_ready_o until that result arrives.
REQ-025 A result clear and an issue set on different IDs in the same cycle both take effect.

Reset
REQ-026 While rst_i is high at a clock edge: FSM=IDLE, next_id=0, outstanding=0, and all valid/ready outputs, ill_o and err_o are 0.
REQ-027 Payload registers reset to 0; reset mid-ISSUE drops the pending offload with no commit.

Configuration
REQ-028 Macro CVXIF_ID_CHECK_EN defined: a result whose ID is not outstanding is consumed (ready per REQ-021), not forwarded, and err_o pulses one cycle.
REQ-029 Macro CVXIF_ID_CHECK_EN undefined: every result is forwarded, err_o is tied 0, and outstanding clears on the received ID regardless.

Structure
REQ-030 The FSM state enum and the commit struct (id, kill) belong in shared package cvxif_initiator_pkg.
REQ-031 The outstanding scoreboard (set/clear/lookup) is sub-module cvxif_id_scoreboard; the remainder stays flat.

Verification
REQ-032 Offload instr=0x0000_000B, rs={5,7}, ready=1, accept=1, writeback=1 -> issue id0 at cycle 1, commit id0 kill=0 at cycle 2; result id0 data=12 rd=3 -> wb_valid_o next cycle with data 12, rd 3.
REQ-033 accept=0 -> ill_o pulses once, commit kill=1, no outstanding bit set, off_ready_o=1 again after COMMIT.
REQ-034 x_issue_ready_i low for 5 cycles -> x_issue_valid_o and payload held constant for 5 cycles; handshake on the 6th cycle.
REQ-035 Depth=4, id0 outstanding and never answered, ids 1-3 complete -> off_ready_o=0 at next_id=0 wrap; result id0 -> off_ready_o=1 the next cycle.
REQ-036 wb_ready_i=0 with wb full -> x_result_ready_o=0; with CVXIF_ID_CHECK_EN, result id=2 not outstanding -> err_o pulses, wb_valid_o stays 0.
